// File: rtl/parking_pkg.sv
// Shared definitions for the countdown bank.
// Holds the per-channel state encoding, the default clock frequency used
// as the prescaler division, and a helper that sizes channel-select buses.
// No ports: this is a package imported by countdown_bank and countdown_channel.
package parking_pkg;

   // Default system clock frequency; one count tick per second at this rate.
   localparam int CLK_HZ = 100000000;

   // RUN is encoded as 1 so the state bit doubles as the "active" flag.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } chan_state_t;

   // Width of a channel index; a single-channel bank still needs one bit.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/countdown_channel.sv
// One countdown channel: a two-state (IDLE/RUN) FSM with a down counter.
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   tick       - one-cycle count strobe from the shared prescaler
//   load       - load strobe already decoded for this channel
//   load_value - start value; zero means "expire immediately"
//   cancel     - cancel strobe already decoded for this channel
//   pause      - hold; ticks are ignored while high
//   remaining  - current count (registered)
//   active     - high while in RUN
//   expired    - one-cycle pulse when the count reaches zero
module countdown_channel
   import parking_pkg::*;
#(
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             cancel,
   input  logic             pause,
   output logic [WIDTH-1:0] remaining,
   output logic             active,
   output logic             expired
);

   chan_state_t      state;
   chan_state_t      state_next;
   logic [WIDTH-1:0] count_next;
   logic             expired_next;

   // State, count and expiry pulse are all held in flops so every output
   // of the channel comes straight from a register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= '0;
         expired   <= 1'b0;
      end else begin
         state     <= state_next;
         remaining <= count_next;
         expired   <= expired_next;
      end
   end

   assign active = (state == RUN);

   // Priority is load, then cancel, then tick. Load restarts the channel
   // from any state and swallows a coincident tick. Cancel beats a final
   // tick, so a cancelled countdown never produces an expiry pulse. RUN
   // always holds a non-zero count, so the decrement cannot wrap.
   always_comb begin
      state_next   = state;
      count_next   = remaining;
      expired_next = 1'b0;
      if (load) begin
         if (load_value != '0) begin
            state_next = RUN;
            count_next = load_value;
         end else begin
            state_next   = IDLE;
            count_next   = '0;
            expired_next = 1'b1;
         end
      end else if (cancel) begin
         if (state == RUN) begin
            state_next = IDLE;
            count_next = '0;
         end
      end else if (state == RUN && tick && !pause && remaining != '0) begin
         count_next = remaining - WIDTH'(1);
         if (remaining == WIDTH'(1)) begin
            state_next   = IDLE;
            expired_next = 1'b1;
         end
      end
   end

endmodule

// File: rtl/countdown_bank.sv
// Bank of independent countdown timers sharing one free-running prescaler.
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   load       - one-cycle load strobe for channel load_ch
//   load_ch    - target of load; values >= CHANNELS are ignored
//   load_value - start value for load
//   cancel     - one-cycle cancel strobe for channel cancel_ch
//   cancel_ch  - target of cancel; values >= CHANNELS are ignored
//   pause      - per-channel hold, freezes that channel's count
//   remaining  - packed counts, channel i at [i*WIDTH +: WIDTH]
//   active     - channel i is running
//   expired    - one-cycle pulse when channel i reaches zero
//   tick       - one-cycle prescaler pulse, every TICK_DIV cycles
module countdown_bank
   import parking_pkg::*;
#(
   parameter  int CHANNELS = 4,
   parameter  int WIDTH    = 7,
   parameter  int TICK_DIV = CLK_HZ,
   localparam int CH_W     = ch_width(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      load,
   input  logic [CH_W-1:0]           load_ch,
   input  logic [WIDTH-1:0]          load_value,
   input  logic                      cancel,
   input  logic [CH_W-1:0]           cancel_ch,
   input  logic [CHANNELS-1:0]       pause,
   output logic [CHANNELS*WIDTH-1:0] remaining,
   output logic [CHANNELS-1:0]       active,
   output logic [CHANNELS-1:0]       expired,
   output logic                      tick
);

   localparam int            PW   = $clog2(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0]       presc;
   logic [CHANNELS-1:0] load_sel;
   logic [CHANNELS-1:0] cancel_sel;

   // Free-running prescaler. It is only ever cleared by reset, never by a
   // load, so all channels share one tick phase. The tick flop is set from
   // the terminal count, which places the first tick TICK_DIV cycles after
   // reset is released.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         tick  <= (presc == LAST);
         presc <= (presc == LAST) ? '0 : presc + PW'(1);
      end
   end

   // Channel-select decode. Only indices that exist are compared, so an
   // out-of-range load_ch or cancel_ch simply matches nothing.
   always_comb begin
      load_sel   = '0;
      cancel_sel = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         load_sel[i]   = load   && (load_ch   == CH_W'(i));
         cancel_sel[i] = cancel && (cancel_ch == CH_W'(i));
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      countdown_channel #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .tick       (tick),
         .load       (load_sel[g]),
         .load_value (load_value),
         .cancel     (cancel_sel[g]),
         .pause      (pause[g]),
         .remaining  (remaining[g*WIDTH +: WIDTH]),
         .active     (active[g]),
         .expired    (expired[g])
      );
   end

endmodule

// File: tb/tb_countdown_bank.sv
// Directed bench for countdown_bank with a fast prescaler (TICK_DIV=4).
// A second instance with five channels exercises an in-range/out-of-range
// channel index that the four-channel bus cannot express.
module tb_countdown_bank;

   localparam int CH = 4;
   localparam int W  = 7;
   localparam int TD = 4;

   logic          clk;
   logic          reset;
   logic          load;
   logic [1:0]    load_ch;
   logic [W-1:0]  load_value;
   logic          cancel;
   logic [1:0]    cancel_ch;
   logic [CH-1:0] pause;
   logic [CH*W-1:0] remaining;
   logic [CH-1:0] active;
   logic [CH-1:0] expired;
   logic          tick;

   logic [2:0]    load_ch_b;
   logic [2:0]    cancel_ch_b;
   logic [4:0]    pause_b;
   logic [5*W-1:0] remaining_b;
   logic [4:0]    active_b;
   logic [4:0]    expired_b;
   logic          tick_b;

   int tests_run;
   int tests_failed;

   countdown_bank #(.CHANNELS(CH), .WIDTH(W), .TICK_DIV(TD)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_ch    (load_ch),
      .load_value (load_value),
      .cancel     (cancel),
      .cancel_ch  (cancel_ch),
      .pause      (pause),
      .remaining  (remaining),
      .active     (active),
      .expired    (expired),
      .tick       (tick)
   );

   countdown_bank #(.CHANNELS(5), .WIDTH(W), .TICK_DIV(TD)) u_dut_b (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_ch    (load_ch_b),
      .load_value (load_value),
      .cancel     (cancel),
      .cancel_ch  (cancel_ch_b),
      .pause      (pause_b),
      .remaining  (remaining_b),
      .active     (active_b),
      .expired    (expired_b),
      .tick       (tick_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] rem_of(input int ch);
      return remaining[ch*W +: W];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until the cycle in which tick is high; the decrement lands on
   // the following edge.
   task automatic wait_tick();
      int n;
      n = 0;
      while (tick !== 1'b1 && n < 12) begin
         step();
         n++;
      end
      if (tick !== 1'b1) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL wait_tick: tick got %b expected 1 within 12 cycles", tick);
      end
   endtask

   task automatic do_load(input int ch, input int val);
      load       = 1'b1;
      load_ch    = 2'(ch);
      load_value = W'(val);
      step();
      load = 1'b0;
   endtask

   task automatic test_reset();
      logic e;
      reset = 1'b1;
      step();
      step();
      tests_run++;
      if (remaining !== '0) begin tests_failed++; $display("[TB] FAIL reset_remaining: got %h expected 0", remaining); end
      tests_run++;
      if (active !== '0) begin tests_failed++; $display("[TB] FAIL reset_active: got %b expected 0", active); end
      tests_run++;
      if (expired !== '0) begin tests_failed++; $display("[TB] FAIL reset_expired: got %b expected 0", expired); end
      tests_run++;
      if (tick !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tick: got %b expected 0", tick); end
      reset = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         step();
         e = (c == 4 || c == 8);
         tests_run++;
         if (tick !== e) begin tests_failed++; $display("[TB] FAIL tick_period c=%0d: got %b expected %b", c, tick, e); end
      end
   endtask

   task automatic test_countdown();
      logic e;
      wait_tick();
      step();
      do_load(2, 3);
      tests_run++;
      if (rem_of(2) !== 7'd3) begin tests_failed++; $display("[TB] FAIL cd_load_rem2: got %0d expected 3", rem_of(2)); end
      tests_run++;
      if (active[2] !== 1'b1) begin tests_failed++; $display("[TB] FAIL cd_load_active2: got %b expected 1", active[2]); end
      for (int k = 0; k < 3; k++) begin
         wait_tick();
         step();
         e = (k == 2);
         tests_run++;
         if (rem_of(2) !== W'(2 - k)) begin tests_failed++; $display("[TB] FAIL cd_step%0d_rem2: got %0d expected %0d", k, rem_of(2), 2 - k); end
         tests_run++;
         if (expired[2] !== e) begin tests_failed++; $display("[TB] FAIL cd_step%0d_expired2: got %b expected %b", k, expired[2], e); end
      end
      tests_run++;
      if (active[2] !== 1'b0) begin tests_failed++; $display("[TB] FAIL cd_done_active2: got %b expected 0", active[2]); end
      step();
      tests_run++;
      if (expired[2] !== 1'b0) begin tests_failed++; $display("[TB] FAIL cd_pulse_width: got %b expected 0", expired[2]); end
   endtask

   task automatic test_pause();
      logic e;
      wait_tick();
      step();
      do_load(0, 5);
      pause[0] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         wait_tick();
         step();
         tests_run++;
         if (rem_of(0) !== 7'd5) begin tests_failed++; $display("[TB] FAIL pause_hold%0d_rem0: got %0d expected 5", k, rem_of(0)); end
         tests_run++;
         if (active[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL pause_hold%0d_active0: got %b expected 1", k, active[0]); end
      end
      pause[0] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         wait_tick();
         step();
         e = (k == 4);
         tests_run++;
         if (rem_of(0) !== W'(4 - k)) begin tests_failed++; $display("[TB] FAIL pause_run%0d_rem0: got %0d expected %0d", k, rem_of(0), 4 - k); end
         tests_run++;
         if (expired[0] !== e) begin tests_failed++; $display("[TB] FAIL pause_run%0d_expired0: got %b expected %b", k, expired[0], e); end
      end
      tests_run++;
      if (active[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL pause_done_active0: got %b expected 0", active[0]); end
   endtask

   task automatic test_cancel();
      logic seen;
      wait_tick();
      step();
      do_load(1, 2);
      wait_tick();
      step();
      tests_run++;
      if (rem_of(1) !== 7'd1) begin tests_failed++; $display("[TB] FAIL cancel_pre_rem1: got %0d expected 1", rem_of(1)); end
      cancel    = 1'b1;
      cancel_ch = 2'd1;
      step();
      cancel = 1'b0;
      tests_run++;
      if (rem_of(1) !== 7'd0) begin tests_failed++; $display("[TB] FAIL cancel_rem1: got %0d expected 0", rem_of(1)); end
      tests_run++;
      if (active[1] !== 1'b0) begin tests_failed++; $display("[TB] FAIL cancel_active1: got %b expected 0", active[1]); end
      seen = expired[1];
      for (int k = 0; k < 10; k++) begin
         step();
         seen = seen | expired[1];
      end
      tests_run++;
      if (seen !== 1'b0) begin tests_failed++; $display("[TB] FAIL cancel_no_expiry1: got %b expected 0", seen); end
   endtask

   task automatic test_zero_and_tick_load();
      do_load(3, 0);
      tests_run++;
      if (expired[3] !== 1'b1) begin tests_failed++; $display("[TB] FAIL zero_expired3: got %b expected 1", expired[3]); end
      tests_run++;
      if (active[3] !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_active3: got %b expected 0", active[3]); end
      step();
      tests_run++;
      if (expired[3] !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_pulse_width3: got %b expected 0", expired[3]); end
      wait_tick();
      do_load(3, 4);
      tests_run++;
      if (rem_of(3) !== 7'd4) begin tests_failed++; $display("[TB] FAIL tickload_rem3: got %0d expected 4", rem_of(3)); end
      for (int k = 0; k < 3; k++) begin
         wait_tick();
         step();
      end
      tests_run++;
      if (rem_of(3) !== 7'd1) begin tests_failed++; $display("[TB] FAIL final_pre_rem3: got %0d expected 1", rem_of(3)); end
      wait_tick();
      cancel    = 1'b1;
      cancel_ch = 2'd3;
      step();
      cancel = 1'b0;
      tests_run++;
      if (rem_of(3) !== 7'd0) begin tests_failed++; $display("[TB] FAIL final_cancel_rem3: got %0d expected 0", rem_of(3)); end
      tests_run++;
      if (expired[3] !== 1'b0) begin tests_failed++; $display("[TB] FAIL final_cancel_expired3: got %b expected 0", expired[3]); end
      tests_run++;
      if (active[3] !== 1'b0) begin tests_failed++; $display("[TB] FAIL final_cancel_active3: got %b expected 0", active[3]); end
   endtask

   task automatic test_back_to_back();
      wait_tick();
      step();
      load       = 1'b1;
      load_ch    = 2'd2;
      load_value = 7'd9;
      cancel     = 1'b1;
      cancel_ch  = 2'd2;
      step();
      tests_run++;
      if (rem_of(2) !== 7'd9) begin tests_failed++; $display("[TB] FAIL loadwins_rem2: got %0d expected 9", rem_of(2)); end
      tests_run++;
      if (active[2] !== 1'b1) begin tests_failed++; $display("[TB] FAIL loadwins_active2: got %b expected 1", active[2]); end
      load_ch    = 2'd0;
      load_value = 7'd7;
      cancel_ch  = 2'd2;
      step();
      load   = 1'b0;
      cancel = 1'b0;
      tests_run++;
      if (rem_of(0) !== 7'd7 || active[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL split_load0: got rem %0d act %b expected rem 7 act 1", rem_of(0), active[0]); end
      tests_run++;
      if (rem_of(2) !== 7'd0 || active[2] !== 1'b0 || expired[2] !== 1'b0) begin tests_failed++; $display("[TB] FAIL split_cancel2: got rem %0d act %b exp %b expected 0 0 0", rem_of(2), active[2], expired[2]); end
   endtask

   task automatic test_out_of_range();
      load       = 1'b1;
      load_ch    = 2'd1;
      load_ch_b  = 3'd5;
      load_value = 7'd9;
      step();
      tests_run++;
      if (active_b !== 5'b00000 || remaining_b !== '0) begin tests_failed++; $display("[TB] FAIL oor_load5: got act %b rem %h expected 0 0", active_b, remaining_b); end
      load_ch_b = 3'd4;
      step();
      load      = 1'b0;
      load_ch_b = 3'd7;
      tests_run++;
      if (active_b !== 5'b10000 || remaining_b[4*W +: W] !== 7'd9) begin tests_failed++; $display("[TB] FAIL inrange_load4: got act %b rem %0d expected 10000 9", active_b, remaining_b[4*W +: W]); end
      cancel      = 1'b1;
      cancel_ch   = 2'd1;
      cancel_ch_b = 3'd6;
      step();
      cancel      = 1'b0;
      cancel_ch_b = 3'd7;
      tests_run++;
      if (active_b !== 5'b10000) begin tests_failed++; $display("[TB] FAIL oor_cancel6: got %b expected 10000", active_b); end
   endtask

   task automatic test_reset_midcount();
      int  n;
      wait_tick();
      step();
      do_load(0, 6);
      do_load(1, 6);
      wait_tick();
      step();
      wait_tick();
      step();
      tests_run++;
      if (rem_of(0) !== 7'd4 || rem_of(1) !== 7'd4) begin tests_failed++; $display("[TB] FAIL mid_pre_rem: got %0d %0d expected 4 4", rem_of(0), rem_of(1)); end
      reset      = 1'b1;
      load       = 1'b1;
      load_ch    = 2'd2;
      load_value = 7'd5;
      step();
      tests_run++;
      if (remaining !== '0 || active !== '0 || expired !== '0 || tick !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_reset: got rem %h act %b exp %b tick %b expected all 0", remaining, active, expired, tick); end
      reset = 1'b0;
      load  = 1'b0;
      n = 0;
      while (n < 10) begin
         step();
         n++;
         if (tick === 1'b1) break;
      end
      tests_run++;
      if (n !== TD || tick !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_first_tick: got %0d cycles expected %0d", n, TD); end
      tests_run++;
      if (remaining !== '0 || active !== '0) begin tests_failed++; $display("[TB] FAIL mid_after_reset: got rem %h act %b expected 0 0", remaining, active); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      load         = 1'b0;
      load_ch      = '0;
      load_value   = '0;
      cancel       = 1'b0;
      cancel_ch    = '0;
      pause        = '0;
      load_ch_b    = 3'd7;
      cancel_ch_b  = 3'd7;
      pause_b      = '0;
      test_reset();
      test_countdown();
      test_pause();
      test_cancel();
      test_zero_and_tick_load();
      test_back_to_back();
      test_out_of_range();
      test_reset_midcount();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
